// File: rtl/mult_control.sv
// rtl/mult_control.sv - shift-and-add multiplier sequencer driving ACC Load/Ad/Sh strobes.
// Optional abort input enabled by defining MULT_CTRL_ABORT_EN.
module mult_control #(
  parameter int N  = 4,
  parameter int CW = $clog2(N)
) (
  input  logic          Clk,
  input  logic          rst_n,
  input  logic          St,
  input  logic          M,
`ifdef MULT_CTRL_ABORT_EN
  input  logic          Abort,
`endif
  output logic          Load,
  output logic          Ad,
  output logic          Sh,
  output logic          Done,
  output logic          Busy,
  output logic [CW-1:0] Cnt
);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} state_t;

  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t state, state_next;
  logic   cnt_clr;
  logic   abort;

`ifdef MULT_CTRL_ABORT_EN
  assign abort = Abort;
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      Cnt   <= '0;
    end else begin
      state <= state_next;
      if (cnt_clr)
        Cnt <= '0;
      else if (Sh && Cnt != LAST)
        Cnt <= Cnt + CW'(1);
    end
  end

  // Cnt is the shift index of the current step; reaching LAST on a shift ends the operation.
  always_comb begin
    state_next = state;
    Load       = 1'b0;
    Ad         = 1'b0;
    Sh         = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE: begin
        Load = St & rst_n;
        if (St) begin
          state_next = ADD;
          cnt_clr    = 1'b1;
        end
      end
      ADD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (M) begin
          Ad         = 1'b1;
          state_next = SHIFT;
        end else begin
          Sh         = 1'b1;
          state_next = (Cnt == LAST) ? DONE : ADD;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          Sh         = 1'b1;
          state_next = (Cnt == LAST) ? DONE : ADD;
        end
      end
      DONE: begin
        if (!St)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Done = (state == DONE);
  assign Busy = (state == ADD) || (state == SHIFT);

endmodule

// File: tb/tb_mult_control.sv
// tb/tb_mult_control.sv - self-checking bench for mult_control with an ACC model in the loop.
module tb_mult_control;
  localparam int N = 4;

  logic       Clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       St = 1'b0;
  logic       M;
  logic       Load, Ad, Sh, Done, Busy;
  logic [1:0] Cnt;
`ifdef MULT_CTRL_ABORT_EN
  logic       Abort = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [3:0] mpl = '0;
  logic [3:0] mc  = '0;
  logic [8:0] acc = '0;

  mult_control #(.N(N)) dut (
    .Clk  (Clk),
    .rst_n(rst_n),
    .St   (St),
    .M    (M),
`ifdef MULT_CTRL_ABORT_EN
    .Abort(Abort),
`endif
    .Load (Load),
    .Ad   (Ad),
    .Sh   (Sh),
    .Done (Done),
    .Busy (Busy),
    .Cnt  (Cnt)
  );

  always #5 Clk = ~Clk;

  // Behavioural ACC: A is acc[8:4], multiplier/product low half is acc[3:0].
  assign M = acc[0];
  always @(posedge Clk) begin
    if (Load)    acc <= {5'b0, mpl};
    else if (Ad) acc[8:4] <= {1'b0, acc[7:4]} + {1'b0, mc};
    else if (Sh) acc <= acc >> 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // 1 = Ad, 2 = Sh
  task automatic run_op(input logic [3:0] mpl_i, input logic [3:0] mc_i, input int exp_lat,
                        input bit hold, input bit pulse);
    int exp_seq[$];
    int got_seq[$];
    int lat = -1;
    int bad = 0;
    int seq_ok;
    for (int i = 0; i < N; i++) begin
      if (mpl_i[i]) exp_seq.push_back(1);
      exp_seq.push_back(2);
    end
    @(negedge Clk);
    mpl = mpl_i;
    mc  = mc_i;
    St  = 1'b1;
    #1;
    chk("start_load", int'(Load), 1);
    for (int cyc = 1; cyc <= 4 * N + 10; cyc++) begin
      @(negedge Clk);
      #1;
      if (Done) begin
        lat = cyc;
        break;
      end
      if (!Busy || Load || (Ad && Sh)) bad++;
      if (Ad) got_seq.push_back(1);
      if (Sh) got_seq.push_back(2);
      if (!hold && cyc == 1) St = 1'b0;
      if (pulse && cyc == 2) St = 1'b1;
      if (pulse && !hold && cyc == 3) St = 1'b0;
    end
    chk("latency", lat, exp_lat);
    chk("busy_strobe_rules", bad, 0);
    seq_ok = (got_seq.size() == exp_seq.size()) ? 1 : 0;
    if (seq_ok == 1)
      for (int i = 0; i < exp_seq.size(); i++)
        if (got_seq[i] != exp_seq[i]) seq_ok = 0;
    chk("strobe_sequence", seq_ok, 1);
    chk("cnt_final", int'(Cnt), N - 1);
    chk("product", int'(acc[7:0]), int'(mpl_i) * int'(mc_i));
    if (hold) begin
      bad = 0;
      repeat (3) begin
        @(negedge Clk);
        #1;
        if (!Done || Load || Busy) bad++;
      end
      chk("done_hold", bad, 0);
    end
    St = 1'b0;
    @(negedge Clk);
    #1;
    chk("done_fall", int'(Done), 0);
    chk("idle_cnt_hold", int'(Cnt), N - 1);
  endtask

  typedef struct {
    logic [3:0] mpl;
    logic [3:0] mc;
    int         lat;
    bit         hold;
    bit         pulse;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{4'b1101, 4'd11, 8, 1'b0, 1'b0};
    tbl[1] = '{4'b0000, 4'd9,  5, 1'b0, 1'b0};
    tbl[2] = '{4'b1111, 4'd15, 9, 1'b1, 1'b0};
    tbl[3] = '{4'b1000, 4'd7,  6, 1'b0, 1'b1};
    tbl[4] = '{4'b0001, 4'd13, 6, 1'b1, 1'b1};
    tbl[5] = '{4'b0110, 4'd0,  7, 1'b0, 1'b0};

    // Reset with St high: everything quiet, Load gated.
    St = 1'b1;
    mpl = 4'b0000;
    mc  = 4'd5;
    #12;
    chk("rst_load", int'(Load), 0);
    chk("rst_strobes", int'(Ad) + int'(Sh), 0);
    chk("rst_done_busy", int'(Done) + int'(Busy), 0);
    chk("rst_cnt", int'(Cnt), 0);
    @(negedge Clk);
    rst_n = 1'b1;
    #1;
    chk("release_load", int'(Load), 1);
    @(negedge Clk);
    #1;
    chk("release_busy", int'(Busy), 1);
    // Second shift of an all-zero multiplier is the second ADD cycle.
    @(negedge Clk);
    #1;
    chk("mid_sh", int'(Sh), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", int'(Load) + int'(Ad) + int'(Sh) + int'(Done) + int'(Busy), 0);
    chk("midrst_cnt", int'(Cnt), 0);
    St = 1'b0;
    @(negedge Clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_idle", int'(Busy) + int'(Done) + int'(Load), 0);

    for (int i = 0; i < 6; i++)
      run_op(tbl[i].mpl, tbl[i].mc, tbl[i].lat, tbl[i].hold, tbl[i].pulse);

    for (int i = 0; i < 20; i++) begin
      logic [3:0] a, b;
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      run_op(a, b, N + 1 + $countones(a), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

`ifdef MULT_CTRL_ABORT_EN
    begin
      int bad = 0;
      @(negedge Clk);
      mpl = 4'b1111;
      mc  = 4'd3;
      St  = 1'b1;
      @(negedge Clk);
      St = 1'b0;
      #1;
      chk("abort_first_ad", int'(Ad), 1);
      @(negedge Clk);
      Abort = 1'b1;
      #1;
      chk("abort_sh_suppressed", int'(Sh) + int'(Ad), 0);
      @(negedge Clk);
      Abort = 1'b0;
      #1;
      chk("abort_idle", int'(Busy), 0);
      chk("abort_cnt", int'(Cnt), 0);
      repeat (4) begin
        @(negedge Clk);
        #1;
        if (Done || Busy) bad++;
      end
      chk("abort_no_done", bad, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
